// File: rtl/csr_ctrl_if.sv
// Pipeline-facing bundle of the CSR/trap unit: decode read port, WB write port,
// WB exception/ertn report, interrupt lines and the flush/redirect to fetch.
interface csr_ctrl_if;
    logic [13:0] csr_rnum;
    logic [31:0] csr_rval;
    logic        csr_we;
    logic [13:0] csr_wnum;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wval;
    logic        wb_exc;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        ertn_flush;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic        flush;
    logic [31:0] flush_target;

    modport master (
        output csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
               wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in,
        input  csr_rval, has_int, flush, flush_target
    );

    modport slave (
        input  csr_rnum, csr_we, csr_wnum, csr_wmask, csr_wval,
               wb_exc, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
               hw_int_in, ipi_int_in,
        output csr_rval, has_int, flush, flush_target
    );
endinterface

// File: rtl/csr_ctrl.sv
// CSR file and trap sequencer: trap state (CRMD/PRMD/ESTAT/ERA/BADV), exception
// and ertn redirect, stable-counter timer and interrupt-pending detection.
module csr_ctrl #(
    parameter int unsigned TIMER_W = 32,
    parameter logic [31:0] TID_RST = 32'h0
) (
    input logic       clk,
    input logic       resetn,
    csr_ctrl_if.slave bus
);

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;
    localparam logic [13:0] CSR_SAVE0  = 14'h030;
    localparam logic [13:0] CSR_SAVE1  = 14'h031;
    localparam logic [13:0] CSR_SAVE2  = 14'h032;
    localparam logic [13:0] CSR_SAVE3  = 14'h033;
    localparam logic [13:0] CSR_TID    = 14'h040;
    localparam logic [13:0] CSR_TCFG   = 14'h041;
    localparam logic [13:0] CSR_TVAL   = 14'h042;
    localparam logic [13:0] CSR_TICLR  = 14'h044;

    localparam logic [31:0] CRMD_RST  = 32'h0000_0008;
    localparam logic [31:0] CRMD_WR   = 32'h0000_000F;
    localparam logic [31:0] PRMD_WR   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WR   = 32'h0000_1BFF;
    localparam logic [31:0] EENTRY_WR = 32'hFFFF_FFC0;
    localparam logic [31:0] TCFG_WR   = 32'hFFFF_FFFF >> (32 - TIMER_W);

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} timer_state_e;

    logic [31:0]        crmd, prmd, ecfg, estat, era, badv, eentry, tid, tcfg;
    logic [31:0]        save [4];
    logic [TIMER_W-1:0] tval, tval_nxt;
    timer_state_e       t_state, t_state_nxt;
    logic               ertn, wr_ok, tcfg_wr, ticlr_hit, timer_fire, has_int_q;
    logic [31:0]        tcfg_new, rval;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] writable,
                                          input logic [31:0] wval, input logic [31:0] wmask);
        return (old & ~(wmask & writable)) | (wval & wmask & writable);
    endfunction

    assign ertn      = bus.ertn_flush & ~bus.wb_exc;
    // The instruction that traps or returns retires no CSR write of its own.
    assign wr_ok     = bus.csr_we & ~(bus.wb_exc | bus.ertn_flush);
    assign tcfg_wr   = wr_ok && (bus.csr_wnum == CSR_TCFG);
    assign tcfg_new  = merge(tcfg, TCFG_WR, bus.csr_wval, bus.csr_wmask);
    assign ticlr_hit = wr_ok && (bus.csr_wnum == CSR_TICLR) && bus.csr_wval[0] && bus.csr_wmask[0];

    assign bus.flush        = bus.wb_exc | bus.ertn_flush;
    assign bus.flush_target = bus.wb_exc ? eentry : era;
    assign bus.has_int      = has_int_q;
    assign bus.csr_rval     = rval;

    // NOTE: sequential state uses <= only, so every read in this block sees the
    // pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd      <= CRMD_RST;
            prmd      <= '0;
            ecfg      <= '0;
            estat     <= '0;
            era       <= '0;
            badv      <= '0;
            eentry    <= '0;
            tid       <= TID_RST;
            tcfg      <= '0;
            has_int_q <= 1'b0;
            // NOTE: the SAVE array is four plain registers, not a RAM macro, so it
            // is reset with everything else.
            for (int i = 0; i < 4; i++) save[i] <= '0;
        end else begin
            estat[9:2] <= bus.hw_int_in;
            estat[12]  <= bus.ipi_int_in;
            if (timer_fire)     estat[11] <= 1'b1;
            else if (ticlr_hit) estat[11] <= 1'b0;
            has_int_q <= crmd[2] & |(estat[12:0] & ecfg[12:0]);

            if (bus.wb_exc) begin
                prmd[2:0]    <= crmd[2:0];
                crmd[2:0]    <= 3'b000;
                era          <= bus.wb_pc;
                estat[21:16] <= bus.wb_ecode;
                estat[30:22] <= bus.wb_esubcode;
                if (bus.wb_ecode == 6'h08 || bus.wb_ecode == 6'h09) badv <= bus.wb_vaddr;
            end else if (ertn) begin
                crmd[2:0] <= prmd[2:0];
            end else if (wr_ok) begin
                case (bus.csr_wnum)
                    CSR_CRMD:   crmd   <= merge(crmd, CRMD_WR, bus.csr_wval, bus.csr_wmask);
                    CSR_PRMD:   prmd   <= merge(prmd, PRMD_WR, bus.csr_wval, bus.csr_wmask);
                    CSR_ECFG:   ecfg   <= merge(ecfg, ECFG_WR, bus.csr_wval, bus.csr_wmask);
                    CSR_ESTAT:  estat[1:0] <= (estat[1:0] & ~bus.csr_wmask[1:0])
                                            | (bus.csr_wval[1:0] & bus.csr_wmask[1:0]);
                    CSR_ERA:    era    <= merge(era, 32'hFFFF_FFFF, bus.csr_wval, bus.csr_wmask);
                    CSR_BADV:   badv   <= merge(badv, 32'hFFFF_FFFF, bus.csr_wval, bus.csr_wmask);
                    CSR_EENTRY: eentry <= merge(eentry, EENTRY_WR, bus.csr_wval, bus.csr_wmask);
                    CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        save[bus.csr_wnum[1:0]] <= merge(save[bus.csr_wnum[1:0]], 32'hFFFF_FFFF,
                                                         bus.csr_wval, bus.csr_wmask);
                    CSR_TID:    tid    <= merge(tid, 32'hFFFF_FFFF, bus.csr_wval, bus.csr_wmask);
                    CSR_TCFG:   tcfg   <= tcfg_new;
                    default:    ;
                endcase
            end
        end
    end

    // Timer: state register, next-state logic, counter datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            t_state <= T_IDLE;
            tval    <= '0;
        end else begin
            t_state <= t_state_nxt;
            tval    <= tval_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        t_state_nxt = t_state;
        if (tcfg_wr)                                          t_state_nxt = tcfg_new[0] ? T_RUN : T_IDLE;
        else if (t_state == T_RUN && tval == '0 && !tcfg[1]) t_state_nxt = T_DONE;
    end

    always_comb begin
        timer_fire = (t_state == T_RUN) && (tval == '0);
        tval_nxt   = tval;
        if (tcfg_wr)                 tval_nxt = {tcfg_new[TIMER_W-1:2], 2'b00};
        else if (timer_fire)         tval_nxt = tcfg[1] ? {tcfg[TIMER_W-1:2], 2'b00} : '0;
        else if (t_state == T_RUN)   tval_nxt = tval - TIMER_W'(1);
    end

    always_comb begin
        rval = '0;
        case (bus.csr_rnum)
            CSR_CRMD:   rval = crmd;
            CSR_PRMD:   rval = prmd;
            CSR_ECFG:   rval = ecfg;
            CSR_ESTAT:  rval = estat;
            CSR_ERA:    rval = era;
            CSR_BADV:   rval = badv;
            CSR_EENTRY: rval = eentry;
            CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3: rval = save[bus.csr_rnum[1:0]];
            CSR_TID:    rval = tid;
            CSR_TCFG:   rval = tcfg;
            CSR_TVAL:   rval = 32'(tval);
            default:    rval = '0;
        endcase
    end

endmodule

// File: tb/tb_csr_ctrl.sv
// Bench for csr_ctrl: register-map vectors, trap/ertn/timer sequences, and a
// randomized run against an address-indexed reference model.
module tb_csr_ctrl;

    logic clk = 1'b0;
    logic resetn;
    always #50 clk = ~clk;

    csr_ctrl_if bus ();

    csr_ctrl #(.TIMER_W(32), .TID_RST(32'h0)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [13:0] wnum;
        logic [31:0] wmask;
        logic [31:0] wval;
        logic [13:0] rnum;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    logic [31:0] mreg [128];
    logic        m_has;
    logic [13:0] addrs [15] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C,
                                14'h030, 14'h031, 14'h032, 14'h033, 14'h040, 14'h041, 14'h042, 14'h044};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.csr_rnum    = '0;
        bus.csr_we      = 1'b0;
        bus.csr_wnum    = '0;
        bus.csr_wmask   = '0;
        bus.csr_wval    = '0;
        bus.wb_exc      = 1'b0;
        bus.wb_ecode    = '0;
        bus.wb_esubcode = '0;
        bus.wb_pc       = '0;
        bus.wb_vaddr    = '0;
        bus.ertn_flush  = 1'b0;
        bus.hw_int_in   = '0;
        bus.ipi_int_in  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        bus.csr_we    = 1'b1;
        bus.csr_wnum  = num;
        bus.csr_wmask = mask;
        bus.csr_wval  = val;
        @(negedge clk);
        bus.csr_we    = 1'b0;
    endtask

    task automatic rd(input logic [13:0] num, output logic [31:0] val);
        bus.csr_rnum = num;
        #1;
        val = bus.csr_rval;
    endtask

    task automatic chk_rd(input string name, input logic [13:0] num, input logic [31:0] exp);
        logic [31:0] v;
        rd(num, v);
        check(name, v, exp);
    endtask

    task automatic chk_is11(input string name, input logic exp);
        logic [31:0] v;
        rd(14'h005, v);
        check(name, {31'b0, v[11]}, {31'b0, exp});
    endtask

    task automatic raise_exc(input logic [5:0] ec, input logic [8:0] es,
                             input logic [31:0] pc, input logic [31:0] va);
        bus.wb_exc      = 1'b1;
        bus.wb_ecode    = ec;
        bus.wb_esubcode = es;
        bus.wb_pc       = pc;
        bus.wb_vaddr    = va;
    endtask

    // Reference model: a plain array of architectural register words, one per
    // CSR address, updated by generic masked writes plus the trap rules.
    function automatic logic [31:0] writable(input logic [13:0] a);
        case (a)
            14'h000: return 32'h0000_000F;
            14'h001: return 32'h0000_0007;
            14'h004: return 32'h0000_1BFF;
            14'h005: return 32'h0000_0003;
            14'h00C: return 32'hFFFF_FFC0;
            14'h006, 14'h007, 14'h030, 14'h031, 14'h032, 14'h033, 14'h040: return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        return (a < 14'd128) ? mreg[a[6:0]] : 32'h0;
    endfunction

    task automatic model_step(input logic we, input logic [13:0] wn, input logic [31:0] wm,
                              input logic [31:0] wv, input logic exc, input logic ertn,
                              input logic [5:0] ec, input logic [8:0] es, input logic [31:0] pc,
                              input logic [31:0] va, input logic [7:0] hw, input logic ipi);
        logic        nxt_has;
        logic [31:0] m;
        nxt_has = mreg[0][2] && ((mreg[5][12:0] & mreg[4][12:0]) != 13'h0);
        if (exc) begin
            mreg[1] = mreg[0] & 32'h7;
            mreg[0] = mreg[0] & ~32'h7;
            mreg[6] = pc;
            mreg[5] = (mreg[5] & ~32'h7FFF_0000) | {1'b0, es, ec, 16'h0};
            if (ec == 6'h08 || ec == 6'h09) mreg[7] = va;
        end else if (ertn) begin
            mreg[0] = (mreg[0] & ~32'h7) | (mreg[1] & 32'h7);
        end else if (we && wn < 14'd128) begin
            m = wm & writable(wn);
            mreg[wn[6:0]] = (mreg[wn[6:0]] & ~m) | (wv & m);
        end
        mreg[5] = (mreg[5] & ~32'h0000_13FC) | (32'(hw) << 2) | (32'(ipi) << 12);
        m_has = nxt_has;
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{14'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h000, 32'h0000_000F};
        vecs[1]  = '{14'h001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h001, 32'h0000_0007};
        vecs[2]  = '{14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h004, 32'h0000_1BFF};
        vecs[3]  = '{14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h005, 32'h0000_0003};
        vecs[4]  = '{14'h006, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 14'h006, 32'hDEAD_BEEF};
        vecs[5]  = '{14'h007, 32'hFFFF_FFFF, 32'hCAFE_F00D, 14'h007, 32'hCAFE_F00D};
        vecs[6]  = '{14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h00C, 32'hFFFF_FFC0};
        vecs[7]  = '{14'h030, 32'hFFFF_FFFF, 32'h1111_1111, 14'h030, 32'h1111_1111};
        vecs[8]  = '{14'h033, 32'hFFFF_FFFF, 32'h4444_4444, 14'h033, 32'h4444_4444};
        vecs[9]  = '{14'h031, 32'hFF00_FF00, 32'hFFFF_FFFF, 14'h031, 32'hFF00_FF00};
        vecs[10] = '{14'h040, 32'hFFFF_FFFF, 32'h0BAD_C0DE, 14'h040, 32'h0BAD_C0DE};
        vecs[11] = '{14'h041, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 14'h041, 32'hFFFF_FFFE};
        vecs[12] = '{14'h042, 32'hFFFF_FFFF, 32'h1234_5678, 14'h042, 32'hFFFF_FFFC};
        vecs[13] = '{14'h044, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h044, 32'h0000_0000};
        vecs[14] = '{14'h002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 14'h002, 32'h0000_0000};
        vecs[15] = '{14'h000, 32'h0000_0003, 32'h0000_0000, 14'h000, 32'h0000_000C};
        vecs[16] = '{14'h030, 32'h0000_0000, 32'hFFFF_FFFF, 14'h030, 32'h1111_1111};

        do_reset();
        chk_rd("rst_crmd", 14'h000, 32'h8);
        chk_rd("rst_estat", 14'h005, 32'h0);
        check("rst_has_int", {31'b0, bus.has_int}, 32'h0);

        for (int i = 0; i < 17; i++) begin
            wr(vecs[i].wnum, vecs[i].wmask, vecs[i].wval);
            chk_rd($sformatf("vec%0d", i), vecs[i].rnum, vecs[i].exp);
        end

        // Asynchronous reset with no clock edge in between
        resetn = 1'b0;
        #1;
        chk_rd("areset_crmd", 14'h000, 32'h8);
        chk_rd("areset_tcfg", 14'h041, 32'h0);
        chk_rd("areset_tval", 14'h042, 32'h0);
        chk_rd("areset_save0", 14'h030, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Exception entry
        wr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8000);
        raise_exc(6'h0B, 9'h005, 32'h1C00_0100, 32'h0000_1234);
        #1;
        check("exc_flush", {31'b0, bus.flush}, 32'h1);
        check("exc_target", bus.flush_target, 32'h1C00_8000);
        @(negedge clk);
        idle();
        chk_rd("exc_era", 14'h006, 32'h1C00_0100);
        chk_rd("exc_estat", 14'h005, 32'h014B_0000);
        chk_rd("exc_crmd", 14'h000, 32'h8);
        chk_rd("exc_badv_kept", 14'h007, 32'h0);
        raise_exc(6'h08, 9'h000, 32'h1C00_0104, 32'hBAD0_0008);
        @(negedge clk);
        idle();
        chk_rd("ade_badv", 14'h007, 32'hBAD0_0008);

        // Trap then return
        wr(14'h000, 32'hF, 32'hF);
        raise_exc(6'h0B, 9'h000, 32'h1C00_0200, 32'h0);
        @(negedge clk);
        idle();
        chk_rd("trap_crmd", 14'h000, 32'h8);
        chk_rd("trap_prmd", 14'h001, 32'h7);
        bus.ertn_flush = 1'b1;
        #1;
        check("ertn_flush", {31'b0, bus.flush}, 32'h1);
        check("ertn_target", bus.flush_target, 32'h1C00_0200);
        @(negedge clk);
        idle();
        chk_rd("ertn_crmd", 14'h000, 32'hF);
        raise_exc(6'h0B, 9'h000, 32'h1C00_0300, 32'h0);
        bus.ertn_flush = 1'b1;
        #1;
        check("exc_over_ertn_target", bus.flush_target, 32'h1C00_8000);
        @(negedge clk);
        idle();
        chk_rd("exc_over_ertn_crmd", 14'h000, 32'h8);
        bus.ertn_flush = 1'b1;
        @(negedge clk);
        idle();

        // Periodic timer with interrupt (CRMD.IE=1 restored above)
        wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_000B);
        chk_rd("tval_load", 14'h042, 32'd8);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk_rd($sformatf("tval_cnt%0d", k), 14'h042, 32'(8 - k));
        end
        @(negedge clk);
        chk_rd("tval_reload", 14'h042, 32'd8);
        chk_is11("fire_is11", 1'b1);
        check("fire_has_int_lag", {31'b0, bus.has_int}, 32'h0);
        @(negedge clk);
        check("fire_has_int", {31'b0, bus.has_int}, 32'h1);
        chk_rd("tval_after_reload", 14'h042, 32'd7);
        wr(14'h044, 32'hFFFF_FFFF, 32'h1);
        chk_is11("ticlr_is11", 1'b0);
        @(negedge clk);
        check("ticlr_has_int", {31'b0, bus.has_int}, 32'h0);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0008);
        repeat (3) @(negedge clk);
        chk_rd("idle_tval_held", 14'h042, 32'd8);

        // One-shot timer, zero InitVal, and fire-versus-clear
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0005);
        repeat (8) @(negedge clk);
        chk_rd("oneshot_tval", 14'h042, 32'd0);
        chk_is11("oneshot_is11", 1'b1);
        wr(14'h044, 32'hFFFF_FFFF, 32'h1);
        chk_is11("done_clear", 1'b0);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0001);
        chk_is11("zero_init_pre", 1'b0);
        @(negedge clk);
        chk_is11("zero_init_fire", 1'b1);
        wr(14'h044, 32'hFFFF_FFFF, 32'h1);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0003);
        chk_is11("per0_pre", 1'b0);
        wr(14'h044, 32'hFFFF_FFFF, 32'h1);
        chk_is11("fire_beats_ticlr", 1'b1);
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0000);
        wr(14'h044, 32'hFFFF_FFFF, 32'h1);
        chk_is11("stopped_clear", 1'b0);

        // Reset in the middle of a timer run
        wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0101);
        repeat (3) @(negedge clk);
        chk_rd("run_tval", 14'h042, 32'h0000_00FD);
        resetn = 1'b0;
        #1;
        chk_rd("midrun_tval", 14'h042, 32'h0);
        chk_rd("midrun_tcfg", 14'h041, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk_rd("post_reset_tval", 14'h042, 32'h0);

        // Masked write, then writes discarded by flush cycles
        wr(14'h030, 32'hFFFF_FFFF, 32'h1234_5678);
        wr(14'h030, 32'h0000_FFFF, 32'hAAAA_5555);
        chk_rd("save0_masked", 14'h030, 32'h1234_5555);
        raise_exc(6'h0B, 9'h000, 32'h1C00_0400, 32'h0);
        wr(14'h030, 32'hFFFF_FFFF, 32'h0);
        idle();
        chk_rd("save0_exc_drop", 14'h030, 32'h1234_5555);
        bus.ertn_flush = 1'b1;
        wr(14'h030, 32'hFFFF_FFFF, 32'h0);
        idle();
        chk_rd("save0_ertn_drop", 14'h030, 32'h1234_5555);

        // Hardware interrupt gated by CRMD.IE
        do_reset();
        wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0020);
        bus.hw_int_in = 8'h08;
        repeat (3) @(negedge clk);
        chk_rd("hw_estat", 14'h005, 32'h0000_0020);
        check("hw_ie0", {31'b0, bus.has_int}, 32'h0);
        wr(14'h000, 32'h4, 32'h4);
        check("hw_ie1_lag", {31'b0, bus.has_int}, 32'h0);
        @(negedge clk);
        check("hw_ie1", {31'b0, bus.has_int}, 32'h1);
        bus.hw_int_in = 8'h00;
        repeat (2) @(negedge clk);
        check("hw_drop", {31'b0, bus.has_int}, 32'h0);

        // Randomized run against the reference model (timer left idle)
        do_reset();
        for (int i = 0; i < 128; i++) mreg[i] = 32'h0;
        mreg[0]    = 32'h8;
        mreg[7'h40] = 32'h0;
        m_has      = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [13:0] ra, wa;
            logic [5:0]  ec;
            ra = ($urandom_range(0, 3) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 14)];
            wa = ($urandom_range(0, 3) == 0) ? 14'($urandom) : addrs[$urandom_range(0, 14)];
            if (wa == 14'h041) wa = 14'h002;
            case ($urandom_range(0, 3))
                0:       ec = 6'h08;
                1:       ec = 6'h09;
                default: ec = 6'($urandom);
            endcase
            bus.csr_rnum    = ra;
            bus.csr_we      = ($urandom_range(0, 1) == 1);
            bus.csr_wnum    = wa;
            bus.csr_wmask   = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            bus.csr_wval    = $urandom;
            bus.wb_exc      = ($urandom_range(0, 7) == 0);
            bus.wb_ecode    = ec;
            bus.wb_esubcode = 9'($urandom);
            bus.wb_pc       = $urandom;
            bus.wb_vaddr    = $urandom;
            bus.ertn_flush  = ($urandom_range(0, 7) == 0);
            bus.hw_int_in   = 8'($urandom);
            bus.ipi_int_in  = ($urandom_range(0, 3) == 0);
            #1;
            check($sformatf("rnd%0d_rd_%h", cyc, ra), bus.csr_rval, m_read(ra));
            check($sformatf("rnd%0d_has_int", cyc), {31'b0, bus.has_int}, {31'b0, m_has});
            check($sformatf("rnd%0d_flush", cyc), {31'b0, bus.flush},
                  {31'b0, bus.wb_exc | bus.ertn_flush});
            if (bus.wb_exc || bus.ertn_flush)
                check($sformatf("rnd%0d_target", cyc), bus.flush_target,
                      bus.wb_exc ? mreg[7'h0C] : mreg[7'h06]);
            model_step(bus.csr_we, bus.csr_wnum, bus.csr_wmask, bus.csr_wval, bus.wb_exc,
                       bus.ertn_flush, bus.wb_ecode, bus.wb_esubcode, bus.wb_pc, bus.wb_vaddr,
                       bus.hw_int_in, bus.ipi_int_in);
            @(negedge clk);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_ctrl.md
Name: csr_ctrl

Overview:
Control/status register file and trap sequencer for the 5-stage pipeline. It consumes the write-back stage's CSR write port, exception report and ertn report. It updates CRMD/PRMD/ESTAT/ERA/BADV state and drives the flush/redirect back to fetch. It also owns the stable-counter timer, interrupt-pending detection and the read port used by decode for csrrd/csrxchg.

Parameters:
TIMER_W, 32, width of TVAL down-counter (≤32; upper read bits zero)
TID_RST, 32'h0, reset value of TID

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
csr_rnum  in  14  read CSR number
csr_rval  out  32  read data (combinational from current state)
csr_we  in  1  write enable from WB
csr_wnum  in  14  write CSR number
csr_wmask  in  32  per-bit write mask
csr_wval  in  32  write data
wb_exc  in  1  exception committed in WB this cycle
wb_ecode  in  6  exception code
wb_esubcode  in  9  exception subcode
wb_pc  in  32  PC of excepting instruction
wb_vaddr  in  32  faulting address for ADE/ALE
ertn_flush  in  1  ertn committed in WB
hw_int_in  in  8  level hardware interrupt lines
ipi_int_in  in  1  inter-processor interrupt level
has_int  out  1  interrupt pending and enabled
flush  out  1  pipeline flush (= wb_exc | ertn_flush)
flush_target  out  32  redirect PC

Behaviour:
- Clock clk; reset resetn, asynchronous, active-low. All state clears on reset.
- Reset values: CRMD = PLV 0, IE 0, DA 1 (bit3). All other CSRs 0, except TID = TID_RST. Outputs follow from state: has_int=0; flush/flush_target are combinational from inputs.
- Address map: CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
- Unmapped reads return 0. Unmapped writes are ignored. Reserved bits read 0.
- Writes take effect at the next edge: new = (old & ~wmask) | (wval & wmask), restricted to writable bits.
- Writable bits:
  - CRMD[3:0]; PRMD[2:0]; ECFG.LIE[12:0] excluding bit10; ESTAT.IS[1:0] only.
  - ERA, BADV, SAVEn, TID: all bits.
  - EENTRY[31:6].
  - TCFG[TIMER_W-1:0].
  - TVAL is read-only.
  - TICLR: writing bit0=1 clears ESTAT.IS[11]; TICLR always reads 0.
- ESTAT.IS[9:2] = hw_int_in and IS[12] = ipi_int_in, sampled every cycle (one-cycle register).
- Exception entry (wb_exc=1):
  - PRMD.PPLV<=CRMD.PLV and PRMD.PIE<=CRMD.IE.
  - CRMD.PLV<=0, CRMD.IE<=0.
  - ERA<=wb_pc; ESTAT.Ecode[21:16]<=wb_ecode; ESTAT.EsubCode[30:22]<=wb_esubcode.
  - BADV<=wb_vaddr if ecode is ADE(0x8) or ALE(0x9), otherwise BADV is unchanged.
  - flush_target=EENTRY (current value).
- ertn (ertn_flush=1, wb_exc=0): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; flush_target=ERA (current value).
- Priority:
  - wb_exc overrides ertn_flush.
  - Any flush cycle discards csr_we for that cycle, i.e. the excepting instruction writes nothing.
  - Outside flush cycles, csr_we writes normally.
- Timer FSM, states IDLE / RUN / DONE:
  - Any TCFG write loads TVAL<={InitVal[TIMER_W-1:2],2'b00}. Next state is RUN if the written En (bit0)=1, else IDLE.
  - RUN: TVAL decrements by 1 per cycle. On TVAL==0 in RUN, IS[11]<=1.
    - Periodic (bit1)=1: reload {InitVal,2'b00} and stay in RUN.
    - Periodic=0: go to DONE with TVAL held at 0.
  - DONE/IDLE: TVAL is held. Clearing En via a TCFG write returns to IDLE.
  - InitVal=0 with En=1: fires on the first RUN cycle.
  - Timer fire and TICLR clear in the same cycle: fire wins (IS[11]=1).
- has_int = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), registered state only (no combinational path from csr_we).
- Reads are combinational on the current state. A read and a write to the same CSR in one cycle return the old value; forwarding is the pipeline's responsibility.
- Reset asserted mid-timer-run or mid-flush: all state clears immediately. flush follows its inputs, which the pipeline holds invalid during reset.

Test Plan:
- Reset, then read 0x0 → 0x8; read 0x5 → 0; has_int=0.
- Write EENTRY=0x1C008000 (mask all ones). Then wb_exc with ecode=0xB, pc=0x1C000100 → flush=1, flush_target=0x1C008000. Next cycle: ERA=0x1C000100, ESTAT[21:16]=0xB, CRMD.IE=0.
- Set CRMD.PLV=3 and IE=1, raise wb_exc, then ertn_flush → flush_target=ERA; CRMD restored to PLV=3, IE=1.
- TCFG=0x0000000B (InitVal 8, periodic, en) with LIE[11]=1 and IE=1 → TVAL counts 8..0. IS[11]=1 and has_int=1 ten cycles after the write edge. TVAL reloads 8. TICLR write of 1 clears IS[11].
- csr_we to SAVE0 with mask 0x0000FFFF, wval 0xAAAA5555 over old 0x12345678 → reads 0x12345555. The same write coincident with wb_exc → SAVE0 unchanged.
- hw_int_in[3]=1 with LIE[5]=1 and IE=0 → has_int=0. Set IE=1 → has_int=1.
